sha3_absorb_ctrl: RTL
=====================

Name: sha3_absorb_ctrl

Overview:
Sequencer for the SHA3 message-absorb path. It accepts the 16-bit AXI-Stream message and splits it into rate-sized blocks of word writes. It applies the SHA3 pad10*1 padding: 0x06 domain byte, zero fill, and 0x80 in the final byte of the block. After each block it hands off to the Keccak permutation core through a start/done handshake. It sits between the stream input and the state-XOR/permutation datapath, replacing ad-hoc TLAST/TUSER driving of the padding unit.

Parameters:
WIDTH, 16, stream word width in bits; fixed at 16, byte 0 = bits[7:0].
RATE_WORDS, 68, words per rate block (1088-bit rate, SHA3-256); legal range 2..84.

Ports:
ACLK  input  1  clock; all logic on rising edge.
ARESETn  input  1  reset, asynchronous assert, active-low.
s_tdata  input  16  message word.
s_tvalid  input  1  input word valid.
s_tready  output  1  input ready.
s_tlast  input  1  final message word.
s_tuser  input  3  valid bytes in the TLAST word: 0, 1 or 2; values 3..7 are treated as 2; ignored when s_tlast=0.
m_word  output  16  word to XOR into the state.
m_idx  output  clog2(RATE_WORDS)  word index within the block.
m_valid  output  1  one-cycle write strobe for m_word/m_idx.
perm_start  output  1  one-cycle pulse that starts a permutation.
perm_done  input  1  one-cycle pulse from the core when the permutation is complete.
msg_done  output  1  one-cycle pulse when the last block's permutation has completed.

Behaviour:
- Reset: state=ABSORB, idx=0, s_tready=0 during reset and 1 the first cycle after; m_word=0, m_idx=0, m_valid=0, perm_start=0, msg_done=0; all flags cleared.
- The states are ABSORB, PAD, PERM, DONE. All outputs are registered.
- ABSORB: s_tready=1.
  - A beat is accepted when s_tvalid&s_tready.
  - The cycle after acceptance: m_valid=1, m_idx=idx, m_word=processed word (latency 1), and idx increments.
- Non-last beat: m_word=s_tdata.
  - If idx==RATE_WORDS-1, go to PERM with final=0.
- Last beat, processed word by n=s_tuser:
  - n=0: 0x0006.
  - n=1: {0x06, s_tdata[7:0]}.
  - n=2: s_tdata unchanged, with pad06_pending=1.
  - If idx==RATE_WORDS-1 and n<2: OR in 0x8000 (n=1 gives 0x86 in byte 1), then go to PERM with final=1.
  - If idx==RATE_WORDS-1 and n=2: go to PERM with final=0 and pad06_pending=1; the next block is all padding.
  - Otherwise go to PAD.
- PAD: s_tready=0. One word is emitted per cycle for idx..RATE_WORDS-1.
  - Each word is 0x0000, except the first word is 0x0006 if pad06_pending (then cleared).
  - Index RATE_WORDS-1 additionally ORs in 0x8000, so a block with only one remaining word gets 0x8006.
  - After the last index, go to PERM with final=1.
- PERM: s_tready=0.
  - perm_start pulses exactly once, in the cycle after the last m_valid of the block.
  - The block waits for perm_done. perm_done in the same cycle as perm_start is not valid and is ignored.
  - On perm_done, idx resets to 0 and the next state is:
    - DONE if final=1;
    - PAD if pad06_pending=1;
    - otherwise ABSORB.
- DONE: msg_done pulses for 1 cycle, then the block returns to ABSORB.
- perm_done outside PERM is ignored.
- m_valid and perm_start are never high in the same cycle.
- s_tvalid while s_tready=0 is held off with no data loss; a new message may start the cycle after msg_done.
- Asynchronous reset mid-block or mid-permutation abandons the message. There is no recovery: the datapath must also be reset.

Test Plan:
1. RATE_WORDS=4, one beat 0xABCD, tlast, tuser=1 -> writes idx0=0x06CD, idx1=0x0000, idx2=0x0000, idx3=0x8000; one perm_start; perm_done gives msg_done 1 cycle later.
2. RATE_WORDS=4, 3 beats, the last with tuser=2 (0x1111, 0x2222, 0x3333) -> idx0..2 = data, idx3=0x8006, single block.
3. RATE_WORDS=4, 4 beats, last tuser=2 -> block 1 = data, perm; block 2 = 0x0006, 0, 0, 0x8000, second perm, then msg_done; exactly 2 perm_start pulses.
4. RATE_WORDS=4, 4 beats, last tuser=1, data 0x00EE -> idx3=0x86EE; exactly 1 perm_start.
5. Default RATE_WORDS=68, 100 full beats with random s_tvalid gaps, last tuser=0 -> block 1 = 68 data words; block 2 = data idx0..30, idx31=0x0006, zeros through idx66, idx67=0x8000. s_tready stays low from block-1 acceptance to perm_done.
6. ARESETn asserted while in PERM, then spurious perm_done after release -> all outputs 0 during reset; no msg_done; next message starts at idx0.

Source files
------------

// File: rtl/sha3_absorb_ctrl.sv
// SHA3 absorb sequencer: turns a 16-bit message stream into rate-sized blocks of
// state-XOR word writes with pad10*1 padding, and handshakes each block to the permutation core.
module sha3_absorb_ctrl #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned RATE_WORDS = 68,
  localparam int unsigned IDX_W     = $clog2(RATE_WORDS)
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic [WIDTH-1:0] s_tdata,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic             s_tlast,
  input  logic [2:0]       s_tuser,
  output logic [WIDTH-1:0] m_word,
  output logic [IDX_W-1:0] m_idx,
  output logic             m_valid,
  output logic             perm_start,
  input  logic             perm_done,
  output logic             msg_done
);

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(RATE_WORDS - 1);
  localparam logic [WIDTH-1:0] DOMAIN_PAD = WIDTH'(16'h0006);
  localparam logic [WIDTH-1:0] FINAL_PAD  = WIDTH'(16'h8000);

  typedef enum logic [1:0] {
    ST_ABSORB = 2'd0,
    ST_PAD    = 2'd1,
    ST_PERM   = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             final_q, final_d;
  logic             pad06_q, pad06_d;
  logic             start_pend_q, start_pend_d;
  logic             s_tready_q, s_tready_d;
  logic [WIDTH-1:0] m_word_q, m_word_d;
  logic [IDX_W-1:0] m_idx_q, m_idx_d;
  logic             m_valid_q, m_valid_d;
  logic             perm_start_q, perm_start_d;
  logic             msg_done_q, msg_done_d;

  logic accept;
  logic last_slot;

  assign accept    = s_tvalid & s_tready_q;
  assign last_slot = (idx_q == LAST_IDX);

  // State register and registered outputs
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q      <= ST_ABSORB;
      idx_q        <= '0;
      final_q      <= 1'b0;
      pad06_q      <= 1'b0;
      start_pend_q <= 1'b0;
      s_tready_q   <= 1'b0;
      m_word_q     <= '0;
      m_idx_q      <= '0;
      m_valid_q    <= 1'b0;
      perm_start_q <= 1'b0;
      msg_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      final_q      <= final_d;
      pad06_q      <= pad06_d;
      start_pend_q <= start_pend_d;
      s_tready_q   <= s_tready_d;
      m_word_q     <= m_word_d;
      m_idx_q      <= m_idx_d;
      m_valid_q    <= m_valid_d;
      perm_start_q <= perm_start_d;
      msg_done_q   <= msg_done_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    final_d      = final_q;
    pad06_d      = pad06_q;
    start_pend_d = start_pend_q;
    m_word_d     = m_word_q;
    m_idx_d      = m_idx_q;
    m_valid_d    = 1'b0;
    perm_start_d = 1'b0;
    msg_done_d   = 1'b0;

    unique case (state_q)
      ST_ABSORB: begin
        if (accept) begin
          m_valid_d = 1'b1;
          m_idx_d   = idx_q;
          idx_d     = idx_q + IDX_W'(1);
          if (!s_tlast) begin
            m_word_d = s_tdata;
            if (last_slot) begin
              state_d      = ST_PERM;
              final_d      = 1'b0;
              start_pend_d = 1'b1;
            end
          end else begin
            if (s_tuser == 3'd0) begin
              m_word_d = DOMAIN_PAD;
            end else if (s_tuser == 3'd1) begin
              m_word_d = WIDTH'({8'h06, s_tdata[7:0]});
            end else begin
              m_word_d = s_tdata;
              pad06_d  = 1'b1;
            end
            if (last_slot) begin
              state_d      = ST_PERM;
              start_pend_d = 1'b1;
              // A full last word leaves the whole padding for a fresh block.
              if (s_tuser < 3'd2) begin
                m_word_d = m_word_d | FINAL_PAD;
                final_d  = 1'b1;
              end else begin
                final_d  = 1'b0;
              end
            end else begin
              state_d = ST_PAD;
            end
          end
        end
      end

      ST_PAD: begin
        m_valid_d = 1'b1;
        m_idx_d   = idx_q;
        m_word_d  = pad06_q ? DOMAIN_PAD : '0;
        pad06_d   = 1'b0;
        if (last_slot) begin
          m_word_d     = m_word_d | FINAL_PAD;
          state_d      = ST_PERM;
          final_d      = 1'b1;
          start_pend_d = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      ST_PERM: begin
        // First PERM cycle still carries the block's last write; start follows it.
        if (start_pend_q) begin
          perm_start_d = 1'b1;
          start_pend_d = 1'b0;
        end else if (perm_done && !perm_start_q) begin
          idx_d = '0;
          if (final_q) begin
            state_d    = ST_DONE;
            final_d    = 1'b0;
            msg_done_d = 1'b1;
          end else if (pad06_q) begin
            state_d = ST_PAD;
          end else begin
            state_d = ST_ABSORB;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_ABSORB;
      end

      default: begin
        state_d = ST_ABSORB;
      end
    endcase
  end

  assign s_tready_d = (state_d == ST_ABSORB);

  assign s_tready   = s_tready_q;
  assign m_word     = m_word_q;
  assign m_idx      = m_idx_q;
  assign m_valid    = m_valid_q;
  assign perm_start = perm_start_q;
  assign msg_done   = msg_done_q;

endmodule
